ofifo_psum: RTL and testbench
=============================

Name: ofifo_psum

Overview:
- Output FIFO directly downstream of a systolic MAC row/array.
- Captures each column's partial sum in a per-column queue when that column's valid bit is high.
- Columns drain skewed in time, so each queue fills independently.
- Presents one aligned row of col psums to the SFU/accumulator stage once every column has data.

Parameters:
- col, 8, number of columns (independent queues)
- psum_bw, 16, width of one partial sum
- depth, 64, entries per column queue; power of 2, >= 2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset; synchronous, active-high
- wr  input  col  per-column push strobe; driven by the MAC row valid bus
- in  input  psum_bw*col  psums; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i]
- rd  input  1  pop one entry from every column
- out  output  psum_bw*col  registered aligned row; same bit mapping as in
- o_valid  output  1  every column holds >= 1 entry
- o_full  output  1  any column holds depth entries
- o_ready  output  1  equals ~o_full; upstream may issue execute
- o_ovf  output  1  sticky: a push was dropped

Behaviour:
- Reset (sync, active-high, takes priority over everything in the same edge):
  - all pointers cleared
  - out = 0, o_valid = 0, o_full = 0, o_ready = 1, o_ovf = 0
  - Reset mid-operation discards all stored data; the cycle after reset behaves as empty.
- Pointers:
  - Per column: wptr and rptr, each log2(depth)+1 bits; the MSB is the wrap bit.
  - count = wptr - rptr (modulo).
  - empty: wptr == rptr.
  - full: low bits equal, wrap bits differ.
- Push, column i, at the posedge with wr[i] = 1:
  - Accepted if the column is not full, OR the column is full and a pop is accepted in the same cycle.
  - Accepted: mem[wptr] <= in slice i; wptr increments, wrapping at depth.
  - Rejected: data dropped, wptr unchanged, o_ovf <= 1 (stays set until reset).
- Pop, all columns together, at the posedge with rd = 1 and o_valid = 1:
  - out <= head entry of each column; every rptr increments.
  - Latency: out is valid on the cycle after the rd edge and holds until the next accepted pop.
  - rd with o_valid = 0 is ignored: no pointer change, out holds.
- Simultaneous push and pop on one column:
  - Both take effect; count unchanged.
  - Pushed data never bypasses to out in the same cycle.
  - With count = 0, the column cannot be popped, because o_valid = 0.
- Flags:
  - o_valid, o_full and o_ready are combinational from the pointers, so they reflect state after the last edge.
  - o_valid = AND over columns of ~empty.
  - o_full = OR over columns of full.
- Columns fill in different cycles (skew up to col-1 cycles). o_valid rises only after the last column receives its entry.
- No arithmetic on data; psums pass through bit-exact.

Decomposition:
- Sub-module fifo_col: one column queue, including pointer/full/empty logic and push acceptance that takes a pop_accept input.
- ofifo_psum instantiates col fifo_col copies via generate and contains:
  - the o_valid AND-reduce
  - the o_full OR-reduce
  - the out register
  - the o_ovf flag
- Shared package holds:
  - localparam ptr_bw = $clog2(depth)+1
  - a helper function for the column slice base index (psum_bw*i)
- No typedefs required.

Test Plan (col=8, psum_bw=16, depth=4 unless stated):
- Reset then idle -> o_valid=0, o_full=0, o_ready=1, o_ovf=0, out=0; rd=1 for 3 cycles leaves all unchanged.
- Skewed fill: wr[i] pulses at cycle t+i with column i value 16'h0100+i -> o_valid=0 through cycle t+7 and 1 after the t+7 edge; rd one cycle -> out = {16'h0107,...,16'h0100} the next cycle, then o_valid=0.
- Fill all columns to 4 entries (values 1..4) -> o_full=1, o_ready=0; further wr=8'hFF with value 9 -> dropped, o_ovf=1; pops return 1,2,3,4 in order.
- Full with simultaneous wr=8'hFF (value 5) and rd -> pop returns 1, push accepted, o_full stays 1, o_ovf stays 0; next pops return 2,3,4,5.
- Wrap-around: 10 push/pop pairs with values 0..9 -> out sequence 0..9 with no loss; pointers wrap twice.
- Reset asserted with 3 entries queued and a rd in flight -> next cycle out=0, o_valid=0, o_ovf=0; a new push of 16'hBEEF to all columns followed by rd -> out = all 16'hBEEF.

Source files
------------

// File: rtl/ofifo_psum_pkg.sv
// ofifo_psum_pkg: shared widths and slice helpers for the psum output FIFO
package ofifo_psum_pkg;
  localparam int col_def = 8;
  localparam int psum_bw_def = 16;
  localparam int depth_def = 64;
  localparam int ptr_bw = $clog2(depth_def) + 1;
  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction
  function automatic int slice_base(input int i, input int bw);
    return bw * i;
  endfunction
endpackage

// File: rtl/ofifo_psum_fifo_col.sv
// fifo_col: one column queue with wrap-bit pointers and push accepted when a same-cycle pop frees a full slot
module fifo_col
  import ofifo_psum_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int depth = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  logic [psum_bw-1:0] i_data,
  input  logic               i_pop,
  output logic [psum_bw-1:0] o_head,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_drop
);
  localparam int pw = ptr_width(depth);
  localparam int aw = pw - 1;
  logic [pw-1:0] r_wptr, r_rptr;
  logic [psum_bw-1:0] r_mem [depth];
  logic w_accept;
  assign o_empty = r_wptr == r_rptr;
  assign o_full = (r_wptr[aw-1:0] == r_rptr[aw-1:0]) && (r_wptr[aw] != r_rptr[aw]);
  assign w_accept = i_push && (!o_full || i_pop);
  assign o_drop = i_push && !w_accept;
  assign o_head = r_mem[r_rptr[aw-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + pw'(1);
      if (i_pop) r_rptr <= r_rptr + pw'(1);
    end
  end
  always_ff @(posedge clk)
    if (w_accept) r_mem[r_wptr[aw-1:0]] <= i_data;
endmodule

// File: rtl/ofifo_psum.sv
// ofifo_psum: per-column psum queues that release one aligned row once every column holds data
module ofifo_psum
  import ofifo_psum_pkg::*;
#(
  parameter int col = 8,
  parameter int psum_bw = 16,
  parameter int depth = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);
  logic [col-1:0] w_empty, w_full, w_drop;
  logic [psum_bw*col-1:0] w_head;
  logic w_pop;
  assign w_pop = rd && o_valid;
  for (genvar g = 0; g < col; g++) begin : g_col
    fifo_col #(.psum_bw(psum_bw), .depth(depth)) u_col (
      .clk    (clk),
      .reset  (reset),
      .i_push (wr[g]),
      .i_data (in[slice_base(g, psum_bw) +: psum_bw]),
      .i_pop  (w_pop),
      .o_head (w_head[slice_base(g, psum_bw) +: psum_bw]),
      .o_empty(w_empty[g]),
      .o_full (w_full[g]),
      .o_drop (w_drop[g])
    );
  end
  assign o_valid = ~|w_empty;
  assign o_full = |w_full;
  assign o_ready = ~o_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      o_ovf <= 1'b0;
    end else begin
      if (w_pop) out <= w_head;
      if (|w_drop) o_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ofifo_psum.sv
// tb_ofifo_psum: directed and random checks of ofifo_psum against a queue model
module tb_ofifo_psum;
  localparam int C = 8, B = 16, D = 4;
  logic clk = 1'b0, reset = 1'b1, rd = 1'b0;
  logic [C-1:0] wr = '0;
  logic [C*B-1:0] in = '0;
  logic [C*B-1:0] out;
  logic o_valid, o_full, o_ready, o_ovf;
  int n_cmp = 0, n_fail = 0;
  logic [B-1:0] q [C][$];
  logic [C*B-1:0] m_out = '0;
  bit m_ovf = 0, m_live = 0;

  ofifo_psum #(.col(C), .psum_bw(B), .depth(D)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    for (int c = 0; c < C; c++) if (q[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < C; c++) if (q[c].size() == D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [C*B-1:0] rep(input logic [B-1:0] v);
    return {C{v}};
  endfunction

  task automatic chk(input string nm, input logic [C*B-1:0] act, input logic [C*B-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit pa;
    if (reset) begin
      for (int c = 0; c < C; c++) q[c].delete();
      m_out = '0;
      m_ovf = 0;
      m_live = 1;
    end else begin
      pa = rd && m_valid();
      if (pa) for (int c = 0; c < C; c++) m_out[c*B +: B] = q[c].pop_front();
      for (int c = 0; c < C; c++)
        if (wr[c]) begin
          if (q[c].size() < D) q[c].push_back(in[c*B +: B]);
          else m_ovf = 1;
        end
    end
  end

  always @(negedge clk)
    if (m_live) begin
      chk("m_out", out, m_out);
      chk("m_valid", {127'b0, o_valid}, {127'b0, m_valid()});
      chk("m_full", {127'b0, o_full}, {127'b0, m_full()});
      chk("m_ready", {127'b0, o_ready}, {127'b0, !m_full()});
      chk("m_ovf", {127'b0, o_ovf}, {127'b0, m_ovf});
    end

  task automatic cyc(input logic [C-1:0] w, input logic [C*B-1:0] d, input logic r, input logic rs);
    @(negedge clk);
    wr = w;
    in = d;
    rd = r;
    reset = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [C*B-1:0] d;
    cyc('0, '0, 0, 1);
    cyc('0, '0, 0, 1);
    chk("rst_out", out, '0);
    chk("rst_valid", {127'b0, o_valid}, 0);
    chk("rst_full", {127'b0, o_full}, 0);
    chk("rst_ready", {127'b0, o_ready}, 1);
    chk("rst_ovf", {127'b0, o_ovf}, 0);
    repeat (3) cyc('0, '0, 1, 0);
    chk("idle_rd_out", out, '0);
    chk("idle_rd_valid", {127'b0, o_valid}, 0);
    d = '0;
    for (int i = 0; i < C; i++) d[i*B +: B] = 16'h0100 + 16'(i);
    for (int i = 0; i < C; i++) begin
      cyc(8'(1 << i), d, 0, 0);
      chk("skew_valid", {127'b0, o_valid}, {127'b0, (i == C - 1)});
    end
    cyc('0, '0, 1, 0);
    chk("skew_out", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("skew_valid_after", {127'b0, o_valid}, 0);
    for (int v = 1; v <= 4; v++) cyc('1, rep(16'(v)), 0, 0);
    chk("fill_full", {127'b0, o_full}, 1);
    chk("fill_ready", {127'b0, o_ready}, 0);
    chk("fill_ovf0", {127'b0, o_ovf}, 0);
    cyc('1, rep(16'd9), 0, 0);
    chk("drop_ovf", {127'b0, o_ovf}, 1);
    for (int v = 1; v <= 4; v++) begin
      cyc('0, '0, 1, 0);
      chk("fill_pop", out, rep(16'(v)));
    end
    cyc('0, '0, 0, 1);
    for (int v = 1; v <= 4; v++) cyc('1, rep(16'(v)), 0, 0);
    cyc('1, rep(16'd5), 1, 0);
    chk("pp_out", out, rep(16'd1));
    chk("pp_full", {127'b0, o_full}, 1);
    chk("pp_ovf", {127'b0, o_ovf}, 0);
    for (int v = 2; v <= 5; v++) begin
      cyc('0, '0, 1, 0);
      chk("pp_pop", out, rep(16'(v)));
    end
    for (int v = 0; v < 10; v++) begin
      cyc('1, rep(16'(v)), 0, 0);
      cyc('0, '0, 1, 0);
      chk("wrap_out", out, rep(16'(v)));
    end
    for (int v = 1; v <= 3; v++) cyc('1, rep(16'(v + 32)), 0, 0);
    cyc('0, '0, 1, 1);
    chk("mid_rst_out", out, '0);
    chk("mid_rst_valid", {127'b0, o_valid}, 0);
    chk("mid_rst_ovf", {127'b0, o_ovf}, 0);
    cyc('1, rep(16'hBEEF), 0, 0);
    cyc('0, '0, 1, 0);
    chk("beef_out", out, rep(16'hBEEF));
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < C; c++) d[c*B +: B] = 16'($urandom);
      cyc(8'($urandom), d, ($urandom_range(0, 9) < 4), ($urandom_range(0, 299) == 0));
    end
    cyc('0, '0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
